// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: FSM state codes, latency counter
// width and the default memory geometry used by the datapath.
package mem_responder_pkg;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 256;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Index width of the array, kept at least one bit for degenerate depths.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM: one write port and one registered read
// port. The storage has no reset; the read register has a synchronous clear.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              CLK,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge CLK) begin
        if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable read/write wait states and a
// valid/ready request, one-cycle response pulse. Optional bounds checking is
// enabled by defining MEM_RESPONDER_BOUNDS_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W  = idx_width(DEPTH);
    localparam int unsigned ADDR_X = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              oob_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic              mem_clr_c;
    logic [DATA_W-1:0] mem_rdata;

`ifdef MEM_RESPONDER_BOUNDS_EN
    assign oob_c = ({1'b0, addr_q} >= ADDR_X'(DEPTH));
`else
    assign oob_c = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        mem_we_c  = 1'b0;
        mem_re_c  = 1'b0;
        mem_clr_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = req_we ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Access edge: out-of-range writes are dropped, reads return zero.
                    err_d   = oob_c;
                    state_d = ST_RESP;
                    if (we_q) begin
                        mem_we_c = ~oob_c;
                    end else if (oob_c) begin
                        mem_clr_c = 1'b1;
                    end else begin
                        mem_re_c = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset overrides any access that would land on the same edge.
    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .CLK     (CLK),
        .we_i    (mem_we_c & ~Reset),
        .re_i    (mem_re_c & ~Reset),
        .clr_i   (mem_clr_c | Reset),
        .addr_i  (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = mem_rdata;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model tracks the
// expected outputs every cycle, and directed sequences pin literal results.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;
    localparam int          PERIOD = 10;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #(PERIOD/2) CLK = ~CLK;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a request waits LAT edges, then responds for one cycle.
    logic [DATA_W-1:0] mm [DEPTH];
    bit                m_busy = 1'b0;
    bit                m_resp = 1'b0;
    int                m_left = 0;
    bit                m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wd = '0;
    logic [DATA_W-1:0] m_rdata = '0;
    bit                m_err = 1'b0;

    function automatic bit is_oob(input logic [ADDR_W-1:0] a);
`ifdef MEM_RESPONDER_BOUNDS_EN
        return int'(a) >= int'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLK) begin
        if (Reset) begin
            m_busy  <= 1'b0;
            m_resp  <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else if (m_resp) begin
            m_resp <= 1'b0;
            m_err  <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_resp <= 1'b1;
                m_err  <= is_oob(m_addr);
                if (m_we) begin
                    if (!is_oob(m_addr)) mm[int'(m_addr) % DEPTH] <= m_wd;
                end else begin
                    m_rdata <= is_oob(m_addr) ? '0 : mm[int'(m_addr) % DEPTH];
                end
            end
            m_left <= m_left - 1;
        end else if (req_valid) begin
            m_busy <= 1'b1;
            m_left <= req_we ? int'(WR_LAT) : int'(RD_LAT);
            m_we   <= req_we;
            m_addr <= req_addr;
            m_wd   <= req_wdata;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("req_ready", DATA_W'(req_ready), DATA_W'(!m_busy && !m_resp));
            chk("busy",      DATA_W'(busy),      DATA_W'(m_busy || m_resp));
            chk("rsp_valid", DATA_W'(rsp_valid), DATA_W'(m_resp));
            chk("rsp_rdata", rsp_rdata,          m_rdata);
            chk("rsp_err",   DATA_W'(rsp_err),   DATA_W'(m_resp && m_err));
        end
    end

    // One request: wait for ready, optionally scramble inputs after accept,
    // measure accept-to-response edges and return the response fields.
    task automatic xact(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input int exp_lat, input bit mutate,
                        output logic [DATA_W-1:0] rd, output logic err);
        int g;
        int n;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 50) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        if (mutate) begin
            req_addr  = ~addr;
            req_wdata = ~wd;
            req_we    = ~we;
        end
        n = 0;
        forever begin
            @(negedge CLK);
            if (rsp_valid || n >= 40) break;
            @(posedge CLK);
            n++;
        end
        chk("latency", DATA_W'(n), DATA_W'(exp_lat));
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    // Hold req_valid high through several accepts and check their spacing.
    task automatic held(input bit we, input int exp_gap);
        time prev;
        time t;
        int  g;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = 8'h40;
        req_wdata = 32'hA000_0000;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            g = 0;
            while (!req_ready && g < 50) begin
                @(negedge CLK);
                g++;
            end
            @(posedge CLK);
            t = $time;
            #1;
            if (i < 3) begin
                req_addr  = we ? ADDR_W'(8'h41 + i) : ((i % 2 == 0) ? 8'h41 : 8'h40);
                req_wdata = 32'hA000_0000 + DATA_W'(i + 1);
            end else begin
                req_valid = 1'b0;
            end
            if (i > 0) chk("accept_gap", DATA_W'((t - prev) / PERIOD), DATA_W'(exp_gap));
            prev = t;
        end
    endtask

    logic [DATA_W-1:0] rd;
    logic              err;

    initial begin
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_ready", DATA_W'(req_ready), 32'd1);
        chk("idle_valid", DATA_W'(rsp_valid), 32'd0);
        chk("idle_busy",  DATA_W'(busy),      32'd0);
        chk("idle_rdata", rsp_rdata,          32'd0);

        xact(1'b1, 8'h10, 32'hDEADBEEF, 1, 1'b0, rd, err);
        xact(1'b0, 8'h10, 32'h0, 2, 1'b0, rd, err);
        chk("read_0x10", rd, 32'hDEADBEEF);

        // Reset during the wait state of a write must leave memory untouched.
        xact(1'b1, 8'h20, 32'h1, 1, 1'b0, rd, err);
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 32'h0000CAFE;
        @(posedge CLK);
        #1 req_valid = 1'b0; Reset = 1'b1;
        @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("abort_valid", DATA_W'(rsp_valid), 32'd0);
        chk("abort_ready", DATA_W'(req_ready), 32'd1);
        repeat (2) @(negedge CLK);
        chk("abort_novalid", DATA_W'(rsp_valid), 32'd0);
        xact(1'b0, 8'h20, 32'h0, 2, 1'b0, rd, err);
        chk("read_0x20", rd, 32'h1);

        // Inputs scrambled after accept must not affect the transaction.
        xact(1'b1, 8'h30, 32'h12345678, 1, 1'b1, rd, err);
        xact(1'b0, 8'h30, 32'h0, 2, 1'b1, rd, err);
        chk("latched_0x30", rd, 32'h12345678);

        held(1'b1, int'(WR_LAT) + 2);
        held(1'b0, int'(RD_LAT) + 2);
        xact(1'b0, 8'h42, 32'h0, 2, 1'b0, rd, err);
        chk("held_0x42", rd, 32'hA000_0002);
        xact(1'b0, 8'h43, 32'h0, 2, 1'b0, rd, err);
        chk("held_0x43", rd, 32'hA000_0003);

        // Reset and a request on the same edge: the request is dropped.
        @(negedge CLK);
        Reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'h0;
        @(posedge CLK);
        #1 Reset = 1'b0; req_valid = 1'b0;
        @(negedge CLK);
        chk("rst_req_ready", DATA_W'(req_ready), 32'd1);
        chk("rst_req_busy",  DATA_W'(busy),      32'd0);
        xact(1'b0, 8'h10, 32'h0, 2, 1'b0, rd, err);
        chk("rst_req_0x10", rd, 32'hDEADBEEF);

        xact(1'b1, 8'h10, 32'h11111111, 1, 1'b0, rd, err);
        xact(1'b1, 8'h90, 32'h99999999, 1, 1'b0, rd, err);
`ifdef MEM_RESPONDER_BOUNDS_EN
        chk("oob_wr_err", DATA_W'(err), 32'd1);
        xact(1'b0, 8'h90, 32'h0, 2, 1'b0, rd, err);
        chk("oob_rd_err",   DATA_W'(err), 32'd1);
        chk("oob_rd_data",  rd, 32'h0);
        xact(1'b0, 8'h10, 32'h0, 2, 1'b0, rd, err);
        chk("oob_0x10_kept", rd, 32'h11111111);
        chk("inrange_err",   DATA_W'(err), 32'd0);
`else
        chk("alias_wr_err", DATA_W'(err), 32'd0);
        xact(1'b0, 8'h90, 32'h0, 2, 1'b0, rd, err);
        chk("alias_rd_err",  DATA_W'(err), 32'd0);
        chk("alias_rd_data", rd, 32'h99999999);
        xact(1'b0, 8'h10, 32'h0, 2, 1'b0, rd, err);
        chk("alias_0x10",    rd, 32'h99999999);
`endif

        repeat (3) @(negedge CLK);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(PERIOD * 5000);
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
